// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies 'locked' and gates the
// system reset release on a stable lock; parks in FAIL after repeated timeouts.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_reset_n,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] loss_count
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int RW    = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_DONE   = CW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retries_q, retries_d;
    logic [CNT_W-1:0] loss_d;
    logic [1:0]       sync_q;
    logic             locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        loss_d    = loss_count;
        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retries_d = retries_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = (retries_q == RETRY_LAST) ? S_FAIL : S_PLL_RST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                // A dropout restarts the full timeout window without a retry.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_DONE) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    if (loss_count != '1) loss_d = loss_count + 1'b1;
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else if (force_relock) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retries_q   <= '0;
            loss_count  <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pll_locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            loss_count  <= loss_d;
            pll_rst     <= (state_d == S_PLL_RST);
            sys_reset_n <= (state_d == S_RUN);
            ready       <= (state_d == S_RUN);
            fail        <= (state_d == S_FAIL);
        end
    end

endmodule
